pwm_motor_drive: RTL

Downstream stage of the PID position loop. Consumes the loop's signed 16-bit output command and drives the H-bridge direction pins M0 and M1 with a fixed-frequency PWM.
- Duty and direction are re-sampled only at PWM period boundaries.
- A direction reversal inserts a dead period with both pins low.
- Sits between the PID block and the top-level M0/M1 pads; the top level applies any open-drain conversion.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_timebase.sv | 43 ++++
 rtl/pwm_motor_drive.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM motor drive.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam int PERIOD_DEF   = 1000;
  localparam int CNT_W_DEF    = 10;
  localparam int SHIFT_DEF    = 5;
  localparam int DEAD_PER_DEF = 1;

  // |cmd| as a 15-bit magnitude; the most negative value saturates to 32767.
  function automatic logic [14:0] abs_sat(input logic [15:0] cmd);
    if (!cmd[15]) begin
      abs_sat = cmd[14:0];
    end else if (cmd == 16'h8000) begin
      abs_sat = 15'h7FFF;
    end else begin
      abs_sat = (~cmd[14:0]) + 15'd1;
    end
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Period counter (0..PERIOD-1) and end-of-period tick for the PWM drive.
// Latency: both registered; the tick is high exactly while cnt==PERIOD-1.
// Backpressure: none; i_run low clears the counter to 0 and suppresses the tick.
module pwm_timebase #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 10
)(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;

  // Next count: wrap after the last cycle, hold at zero when not running.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_run && (r_cnt != LAST)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Count and tick registers; the tick is precomputed from the next count so it coincides with cnt==LAST.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= i_run && (w_cnt_nxt == LAST);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tick = r_tick;

endmodule

// File: rtl/pwm_motor_drive.sv
// H-bridge PWM driver: turns a signed command into M0/M1 PWM with dead periods on reversal.
// Latency: M0/M1 registered, one cycle behind the period counter; Cmd sampled only at period boundaries.
// Backpressure: none; En low forces the outputs off on the next edge.
module pwm_motor_drive
  import pwm_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SHIFT    = SHIFT_DEF,
  parameter int DEAD_PER = DEAD_PER_DEF
)(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [15:0]      Cmd,
  output logic             M0,
  output logic             M1,
  output logic             Dir,
  output logic             Dead,
  output logic [CNT_W-1:0] Duty,
  output logic             Period_Tick
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tick;
  logic             w_run;
  logic [14:0]      w_mag;
  logic [14:0]      w_raw;
  logic [CNT_W:0]   w_req_duty;
  logic             w_req_rev;
  // One extra bit so a duty equal to a full 2^CNT_W period is representable.
  logic [CNT_W:0]   r_duty_q;
  logic [3:0]       r_dead_cnt;
  logic             r_dir;
  logic             r_m0;
  logic             r_m1;
  logic             w_m0_nxt;
  logic             w_m1_nxt;

  assign w_mag      = abs_sat(Cmd);
  assign w_raw      = w_mag >> SHIFT;
  assign w_req_rev  = Cmd[15];
  assign w_req_duty = (32'(w_raw) > 32'(PERIOD)) ? (CNT_W+1)'(PERIOD) : (CNT_W+1)'(w_raw);
  assign w_run      = En && (r_state != ST_OFF);

  pwm_timebase #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_timebase (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .i_run  (w_run),
    .o_cnt  (w_cnt),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_OFF;
    else        r_state <= w_state_nxt;
  end

  // Next state: En low wins everywhere; otherwise moves happen only at period boundaries.
  always_comb begin
    w_state_nxt = r_state;
    if (!En) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:  w_state_nxt = w_req_rev ? ST_REV : ST_FWD;
        ST_FWD:  if (w_tick && w_req_rev)  w_state_nxt = ST_DEAD;
        ST_REV:  if (w_tick && !w_req_rev) w_state_nxt = ST_DEAD;
        ST_DEAD: if (w_tick && (r_dead_cnt == 4'd1)) w_state_nxt = w_req_rev ? ST_REV : ST_FWD;
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Duty, direction and dead-period bookkeeping, updated at the same points the state may move.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_duty_q   <= '0;
      r_dead_cnt <= '0;
      r_dir      <= 1'b0;
    end else if (!En) begin
      r_duty_q   <= '0;
      r_dead_cnt <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_duty_q <= w_req_duty;
          r_dir    <= w_req_rev;
        end
        ST_FWD, ST_REV: begin
          if (w_tick) begin
            if (w_req_rev == r_dir) begin
              r_duty_q <= w_req_duty;
            end else begin
              r_duty_q   <= '0;
              r_dead_cnt <= 4'(DEAD_PER);
            end
          end
        end
        default: begin
          if (w_tick) begin
            r_dead_cnt <= r_dead_cnt - 4'd1;
            if (r_dead_cnt == 4'd1) begin
              r_duty_q <= w_req_duty;
              r_dir    <= w_req_rev;
            end
          end
        end
      endcase
    end
  end

  // Pin drive: only the active direction's pin can be on, so M0/M1 stay mutually exclusive.
  always_comb begin
    w_m0_nxt = En && (r_state == ST_FWD) && ({1'b0, w_cnt} < r_duty_q);
    w_m1_nxt = En && (r_state == ST_REV) && ({1'b0, w_cnt} < r_duty_q);
  end

  // Registered pins for glitch-free pad drive.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_m0 <= 1'b0;
      r_m1 <= 1'b0;
    end else begin
      r_m0 <= w_m0_nxt;
      r_m1 <= w_m1_nxt;
    end
  end

  assign M0          = r_m0;
  assign M1          = r_m1;
  assign Dir         = r_dir;
  assign Dead        = (r_state == ST_DEAD) || (r_state == ST_OFF);
  assign Duty        = r_duty_q[CNT_W-1:0];
  assign Period_Tick = w_tick;

endmodule
